// File: rtl/time_set_ctrl_if.sv
// Signal bundle between the time-setting controller and its environment.
// The DUT connects through the slave modport; the master modport is the driver's view.
interface time_set_ctrl_if;
  logic       sec_tick;
  logic       rpt_tick;
  logic       pb_mode;
  logic       pb_inc;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [1:0] mode;
  logic       blink;

  modport master (
    output sec_tick, rpt_tick, pb_mode, pb_inc,
    input  hours, minutes, seconds, mode, blink
  );

  modport slave (
    input  sec_tick, rpt_tick, pb_mode, pb_inc,
    output hours, minutes, seconds, mode, blink
  );
endinterface

// File: rtl/time_set_ctrl.sv
// Clock time keeper with RUN / SET_HR / SET_MIN editing via two push buttons.
// Optional macro TIME_SET_AUTO_REPEAT_EN adds hold-to-repeat on pb_inc.
module time_set_ctrl #(
  parameter int unsigned REPEAT_DELAY = 4
) (
  input  logic            clk_in,
  input  logic            clr,
  time_set_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2,
    ST_BAD     = 2'd3
  } state_t;

  if (REPEAT_DELAY < 1 || REPEAT_DELAY > 15) begin : g_param_check
    $error("REPEAT_DELAY must be in 1..15");
  end

  state_t     r_state;
  state_t     w_state_next;
  logic       r_mode_prev;
  logic       r_inc_prev;
  logic       r_blink;
  logic [4:0] r_hours;
  logic [5:0] r_minutes;
  logic [5:0] r_seconds;

  logic w_mode_press;
  logic w_inc_press;
  logic w_inc_evt;
  logic w_in_set;
  logic w_run_tick;
  logic w_sec_wrap;
  logic w_min_wrap;
  logic w_hr_wrap;

  // Previous-value registers come out of reset high so a held button is not a press.
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state is written with <= so every register sees pre-edge values.
    if (clr) begin
      r_mode_prev <= 1'b1;
      r_inc_prev  <= 1'b1;
    end else begin
      r_mode_prev <= bus.pb_mode;
      r_inc_prev  <= bus.pb_inc;
    end
  end

  assign w_mode_press = bus.pb_mode & ~r_mode_prev;
  assign w_inc_press  = bus.pb_inc & ~r_inc_prev & ~w_mode_press;
  assign w_in_set     = (r_state == ST_SET_HR) || (r_state == ST_SET_MIN);

  always_ff @(posedge clk_in) begin
    if (clr) r_state <= ST_RUN;
    else     r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: the default assignment first keeps this block free of inferred latches.
    w_state_next = r_state;
    case (r_state)
      ST_RUN:     if (w_mode_press) w_state_next = ST_SET_HR;
      ST_SET_HR:  if (w_mode_press) w_state_next = ST_SET_MIN;
      ST_SET_MIN: if (w_mode_press) w_state_next = ST_RUN;
      default:    w_state_next = ST_RUN;
    endcase
  end

`ifdef TIME_SET_AUTO_REPEAT_EN
  logic [3:0] r_rpt_cnt;
  logic       w_rpt_fire;

  assign w_rpt_fire = w_in_set & bus.pb_inc & bus.rpt_tick & ~w_mode_press
                    & (r_rpt_cnt == 4'(REPEAT_DELAY));

  // Counts held rpt_ticks up to the delay, then saturates while repeats fire.
  always_ff @(posedge clk_in) begin
    if (clr || !bus.pb_inc || w_mode_press || !w_in_set)
      r_rpt_cnt <= 4'd0;
    else if (bus.rpt_tick && (r_rpt_cnt != 4'(REPEAT_DELAY)))
      r_rpt_cnt <= r_rpt_cnt + 4'd1;
  end

  assign w_inc_evt = w_inc_press | w_rpt_fire;
`else
  assign w_inc_evt = w_inc_press;
`endif

  assign w_run_tick = (r_state == ST_RUN) & bus.sec_tick;
  assign w_sec_wrap = (r_seconds == 6'd59);
  assign w_min_wrap = (r_minutes == 6'd59);
  assign w_hr_wrap  = (r_hours == 5'd23);

  always_ff @(posedge clk_in) begin
    if (clr) begin
      r_hours   <= 5'd0;
      r_minutes <= 6'd0;
      r_seconds <= 6'd0;
    end else begin
      if (w_run_tick) begin
        r_seconds <= w_sec_wrap ? 6'd0 : r_seconds + 6'd1;
        if (w_sec_wrap) begin
          r_minutes <= w_min_wrap ? 6'd0 : r_minutes + 6'd1;
          if (w_min_wrap) r_hours <= w_hr_wrap ? 5'd0 : r_hours + 5'd1;
        end
      end else if ((r_state == ST_SET_HR) && w_inc_evt) begin
        r_hours <= w_hr_wrap ? 5'd0 : r_hours + 5'd1;
      end else if ((r_state == ST_SET_MIN) && w_inc_evt) begin
        r_minutes <= w_min_wrap ? 6'd0 : r_minutes + 6'd1;
      end
      if ((r_state == ST_SET_MIN) && w_mode_press) r_seconds <= 6'd0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (clr)                         r_blink <= 1'b0;
    else if (w_state_next == ST_RUN) r_blink <= 1'b0;
    else if (w_state_next != r_state) r_blink <= 1'b1;
    else if (bus.rpt_tick)           r_blink <= ~r_blink;
  end

  assign bus.hours   = r_hours;
  assign bus.minutes = r_minutes;
  assign bus.seconds = r_seconds;
  assign bus.mode    = r_state;
  assign bus.blink   = r_blink;

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 SHALL have parameter REPEAT_DELAY, default 4, meaning the number of rpt_tick pulses pb_inc must be held before auto-repeat starts (range 1..15).
REQ-002 SHALL have port clk_in, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port clr, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port sec_tick, input, 1, 1-cycle strobe at 1 Hz.
REQ-005 SHALL have port rpt_tick, input, 1, 1-cycle strobe at 4 Hz.
REQ-006 SHALL have port pb_mode, input, 1, debounced mode button, level, high = pressed.
REQ-007 SHALL have port pb_inc, input, 1, debounced increment button, level, high = pressed.
REQ-008 SHALL have port hours, output, 5, current hour, 0..23.
REQ-009 SHALL have port minutes, output, 6, current minute, 0..59.
REQ-010 SHALL have port seconds, output, 6, current second, 0..59.
REQ-011 SHALL have port mode, output, 2, state: 0 = RUN, 1 = SET_HR, 2 = SET_MIN.
REQ-012 SHALL have port blink, output, 1, display blink enable for the field being edited.

Function
REQ-013 SHALL derive press events from rising edges only: a press is pb high in this cycle and low in the previous cycle (previous-value register).
REQ-014 SHALL implement FSM RUN -> SET_HR -> SET_MIN -> RUN, advancing once per pb_mode press event; encoding 3 SHALL never occur and SHALL return to RUN on the next cycle.
REQ-015 SHALL, in RUN, advance time on each sec_tick:
- seconds 59 -> 0 with carry to minutes
- minutes 59 -> 0 with carry to hours
- hours 23 -> 0
- all carries resolve in the same cycle
REQ-016 SHALL ignore sec_tick in SET_HR and SET_MIN; time is frozen.
REQ-017 SHALL, on a pb_inc press in SET_HR, increment hours with wrap 23 -> 0 and no carry.
REQ-018 SHALL, on a pb_inc press in SET_MIN, increment minutes with wrap 59 -> 0 and no carry.
REQ-019 SHALL ignore pb_inc in RUN.
REQ-020 SHALL clear seconds to 0 on the SET_MIN -> RUN transition.
REQ-021 SHALL, on a simultaneous pb_mode and pb_inc press in the same cycle, apply the mode transition only and discard the inc event.
REQ-022 SHALL, on sec_tick coinciding with the RUN -> SET_HR press, apply the increment first; freezing begins the next cycle.
REQ-023 SHALL drive blink low in RUN; in SET states it toggles on each rpt_tick; it SHALL be forced to 1 on entry to each SET state.
REQ-024 SHALL update all outputs one cycle after the causing input edge or strobe (registered outputs).

Reset
REQ-025 SHALL, with clr high at a clk_in edge, set:
- hours = 0, minutes = 0, seconds = 0
- mode = RUN, blink = 0
- repeat counter = 0
REQ-026 SHALL reset the edge-detect registers to 1 so that buttons held through reset generate no press event.
REQ-027 SHALL let clr override all other inputs, including mid-edit and coincident ticks.

Configuration
REQ-028 SHALL support macro TIME_SET_AUTO_REPEAT_EN.
- Defined: in a SET state, while pb_inc stays high, rpt_tick pulses are counted; after REPEAT_DELAY pulses, every further rpt_tick produces one increment of the selected field. The counter clears on pb_inc low, on any mode change, or on clr.
- Undefined: no repeat counter is built; only press edges increment.

Verification
REQ-029 SHALL cover: reset, then 60 sec_tick -> seconds = 0, minutes = 1; preset 23:59:59 plus 1 sec_tick -> 00:00:00.
REQ-030 SHALL cover: mode press, then 3 inc presses -> mode = 1, hours = 3; in SET_HR, 10 sec_ticks -> seconds unchanged.
REQ-031 SHALL cover: minutes = 59 in SET_MIN, 1 inc press -> minutes = 0 and hours unchanged; next mode press -> mode = 0, seconds = 0.
REQ-032 SHALL cover: pb_mode and pb_inc rising in the same cycle in SET_HR with hours = 5 -> mode = 2, hours = 5.
REQ-033 SHALL cover (with TIME_SET_AUTO_REPEAT_EN, REPEAT_DELAY = 4): in SET_HR, hold pb_inc across 8 rpt_ticks -> hours = 0 + 1 (press) + 4 = 5; without the macro, hours = 1.
REQ-034 SHALL cover: pb_inc held high while clr is asserted and then released -> no increment; clr asserted in SET_MIN -> all fields 0 and mode = 0 next cycle.
